// File: rtl/usbh_pkg.sv
// Shared encodings for the USB 1.x transmit path: FSM states, per-bit commands, line codes.
// Line codes are {dp, dn}; J/K polarity depends on the port speed.
package usbh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    typedef enum logic [1:0] {
        CMD_DATA,
        CMD_SE0,
        CMD_J
    } bit_cmd_e;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;
    localparam logic [1:0] LINE_SE0    = 2'b00;

    function automatic logic [1:0] line_j(input logic fs);
        return fs ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] line_k(input logic fs);
        return fs ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/usbh_phy_tx_if.sv
// Byte stream handshake from the host packet engine into the serial transmitter.
// s_ready is a single-cycle capture strobe, not a level.
interface usbh_phy_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/usbh_tx_nrzi_stuff.sv
// Per-bit line encoder: ones counter, stuff-bit insertion, NRZI level and dp/dn mapping.
// Latency: line register updates on the bit_stb_i edge; no backpressure, stuff_pend_o tells the caller to hold its bit.
module usbh_tx_nrzi_stuff
    import usbh_pkg::*;
#(
    parameter logic C_usb_speed = 1'b0
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     bit_stb_i,
    input  bit_cmd_e cmd_i,
    input  logic     data_bit_i,
    input  logic     stuff_dis_i,
    output logic     stuff_pend_o,
    output logic     dp_o,
    output logic     dn_o
);
    logic [2:0] ones_q, ones_d;
    logic       lvl_k_q, lvl_k_d;
    logic [1:0] line_q, line_d;

    assign stuff_pend_o = (ones_q == 3'(STUFF_LIMIT)) && !stuff_dis_i;
    assign dp_o         = line_q[1];
    assign dn_o         = line_q[0];

    always_comb begin
        ones_d  = ones_q;
        lvl_k_d = lvl_k_q;
        line_d  = line_q;
        if (bit_stb_i) begin
            case (cmd_i)
                CMD_DATA: begin
                    // A pending stuff bit pre-empts the data bit; it is sent as a 0 (toggle).
                    if (stuff_pend_o || !data_bit_i) begin
                        lvl_k_d = !lvl_k_q;
                        ones_d  = 3'd0;
                    end else if (ones_q != 3'd7) begin
                        ones_d = ones_q + 3'd1;
                    end
                    line_d = lvl_k_d ? line_k(C_usb_speed) : line_j(C_usb_speed);
                end
                CMD_SE0: begin
                    lvl_k_d = 1'b0;
                    ones_d  = 3'd0;
                    line_d  = LINE_SE0;
                end
                default: begin
                    lvl_k_d = 1'b0;
                    ones_d  = 3'd0;
                    line_d  = line_j(C_usb_speed);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ones_q  <= 3'd0;
            lvl_k_q <= 1'b0;
            line_q  <= line_j(C_usb_speed);
        end else begin
            ones_q  <= ones_d;
            lvl_k_q <= lvl_k_d;
            line_q  <= line_d;
        end
    end
endmodule

// File: rtl/usbh_phy_tx.sv
// USB 1.x serial transmitter: SYNC, bytes LSB first with stuffing/NRZI, EOP; optional LS keep-alive (USBH_TX_KEEPALIVE_EN).
// Latency: line goes active the cycle after s_valid is sampled in IDLE; each bit lasts C_clk_per_bit clocks.
// Backpressure: s_ready pulses once per byte at the load point; a missing byte forces an underrun packet abort.
module usbh_phy_tx
    import usbh_pkg::*;
#(
    parameter logic C_usb_speed   = 1'b0,
    parameter int   C_clk_per_bit = 4
) (
    input  logic         clk,
    input  logic         resetn,
    usbh_phy_tx_if.slave s_if,
    input  logic         keepalive_req,
    output logic         usb_dp_o,
    output logic         usb_dn_o,
    output logic         usb_oe,
    output logic         busy,
    output logic         underrun
);
    localparam int            CW       = (C_clk_per_bit > 1) ? $clog2(C_clk_per_bit) : 1;
    localparam logic [CW-1:0] CNT_WRAP = CW'(C_clk_per_bit - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic          last_q, last_d;
    logic          undr_q, undr_d;
    logic          eop2_q, eop2_d;
    logic          oe_q, oe_d;
    logic          bit_end, byte_end, stuff_pend, bit_stb, data_bit, ka_go;
    bit_cmd_e      cmd;

`ifdef USBH_TX_KEEPALIVE_EN
    assign ka_go = keepalive_req;
`else
    logic unused_ka;
    assign unused_ka = keepalive_req;
    assign ka_go     = 1'b0;
`endif

    assign bit_end  = (state_q != ST_IDLE) && (cnt_q == CNT_WRAP);
    assign byte_end = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && bit_end
                      && !stuff_pend && (bitidx_q == 3'd7);
    // last_q also covers the underrun filler byte, so no load is offered after it.
    assign s_if.s_ready = byte_end && !last_q && s_if.s_valid;
    assign underrun     = byte_end && !last_q && !s_if.s_valid;
    assign usb_oe       = oe_q;
    assign busy         = oe_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
        shreg_d  = shreg_q;
        bitidx_d = bitidx_q;
        last_d   = last_q;
        undr_d   = undr_q;
        eop2_d   = eop2_q;
        oe_d     = oe_q;
        bit_stb  = 1'b0;
        cmd      = CMD_DATA;
        data_bit = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s_if.s_valid) begin
                    state_d  = ST_SYNC;
                    oe_d     = 1'b1;
                    shreg_d  = SYNC_BYTE;
                    bitidx_d = 3'd0;
                    last_d   = 1'b0;
                    undr_d   = 1'b0;
                    bit_stb  = 1'b1;
                    data_bit = SYNC_BYTE[0];
                end else if (ka_go) begin
                    state_d = ST_EOP_SE0;
                    oe_d    = 1'b1;
                    eop2_d  = 1'b0;
                    bit_stb = 1'b1;
                    cmd     = CMD_SE0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (bit_end) begin
                    bit_stb = 1'b1;
                    if (stuff_pend) begin
                        bitidx_d = bitidx_q;
                    end else if (bitidx_q != 3'd7) begin
                        bitidx_d = bitidx_q + 3'd1;
                        data_bit = shreg_q[bitidx_q + 3'd1];
                    end else if (last_q) begin
                        state_d = ST_EOP_SE0;
                        cmd     = CMD_SE0;
                        eop2_d  = 1'b0;
                    end else if (s_if.s_valid) begin
                        state_d  = ST_DATA;
                        shreg_d  = s_if.s_data;
                        last_d   = s_if.s_last;
                        bitidx_d = 3'd0;
                        data_bit = s_if.s_data[0];
                    end else begin
                        // Underrun: eight unstuffed ones make the receiver see a stuff error.
                        state_d  = ST_DATA;
                        shreg_d  = 8'hFF;
                        last_d   = 1'b1;
                        undr_d   = 1'b1;
                        bitidx_d = 3'd0;
                        data_bit = 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    bit_stb = 1'b1;
                    if (!eop2_q) begin
                        eop2_d = 1'b1;
                        cmd    = CMD_SE0;
                    end else begin
                        state_d = ST_EOP_J;
                        cmd     = CMD_J;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    undr_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= 8'h00;
            bitidx_q <= 3'd0;
            last_q   <= 1'b0;
            undr_q   <= 1'b0;
            eop2_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            bitidx_q <= bitidx_d;
            last_q   <= last_d;
            undr_q   <= undr_d;
            eop2_q   <= eop2_d;
            oe_q     <= oe_d;
        end
    end

    usbh_tx_nrzi_stuff #(.C_usb_speed(C_usb_speed)) u_nrzi (
        .clk          (clk),
        .resetn       (resetn),
        .bit_stb_i    (bit_stb),
        .cmd_i        (cmd),
        .data_bit_i   (data_bit),
        .stuff_dis_i  (undr_q),
        .stuff_pend_o (stuff_pend),
        .dp_o         (usb_dp_o),
        .dn_o         (usb_dn_o)
    );
endmodule
